// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel.
//
// Holds one word per channel so that a stalled consumer blocks only the words
// addressed to it. The slot is FULL exactly while valid is high. The caller only
// raises wr_en when the slot is empty or is being drained in the same cycle, so a
// held word never changes while valid=1 and rd_ready=0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears valid and data)
//   wr_en     load wr_data into the slot at the next edge
//   wr_data   word to store
//   rd_ready  consumer ready; drains a FULL slot when no write is pending
//   valid     slot holds a word
//   data      held word (keeps its last value once drained)
module demux_slot #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (wr_en) begin
      // A write wins over a drain: FULL stays FULL with the new word.
      valid_q <= 1'b1;
      data_q  <= wr_data;
    end else if (rd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_generic_buf.sv
// Generic 1:N demultiplexer with valid/ready handshake and per-channel buffering.
//
// Routes each accepted input word to the output channel chosen by in_sel. Every
// channel has its own one-entry slot, so backpressure on one channel stalls only
// words addressed to it. Words with in_sel >= DEMUX_SIZE are accepted, dropped and
// counted in a saturating error counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   input word accepted when in_valid & in_ready (never depends on in_valid)
//   in_sel     destination channel of the input word
//   in_data    input word
//   out_valid  per-channel word valid
//   out_ready  per-channel consumer ready
//   out_data   channel c occupies bits [c*DATA_W +: DATA_W]
//   err_cnt    saturating count of dropped out-of-range words
//   err_clr    synchronous clear of err_cnt (a same-cycle drop still counts)
module demux_generic_buf #(
  parameter int unsigned    DEMUX_SIZE = 8,
  parameter int unsigned    DATA_W     = 1,
  parameter int unsigned    ERR_W      = 8,
  localparam int unsigned   SEL_W      = (DEMUX_SIZE > 1) ? $clog2(DEMUX_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             in_sel,
  input  logic [DATA_W-1:0]            in_data,
  output logic [DEMUX_SIZE-1:0]        out_valid,
  input  logic [DEMUX_SIZE-1:0]        out_ready,
  output logic [DEMUX_SIZE*DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]             err_cnt,
  input  logic                         err_clr
);

  // One extra bit so that the channel count itself is representable (N=2^SEL_W).
  localparam logic [SEL_W:0] NumCh = (SEL_W + 1)'(DEMUX_SIZE);

  logic                  sel_ok;
  logic                  accept;
  logic                  drop;
  logic [DEMUX_SIZE-1:0] wr_en;
  logic [ERR_W-1:0]      err_cnt_q;
  logic [ERR_W-1:0]      err_cnt_d;

  assign sel_ok = ({1'b0, in_sel} < NumCh);

  // Ready is a combinational pass-through of the addressed channel's state, so a
  // full slot that is draining this cycle can take a new word back-to-back.
  always_comb begin
    in_ready = 1'b1;
    if (sel_ok) begin
      in_ready = !out_valid[in_sel] || out_ready[in_sel];
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !sel_ok;

  always_comb begin
    wr_en = '0;
    for (int c = 0; c < int'(DEMUX_SIZE); c++) begin
      wr_en[c] = accept && sel_ok && (in_sel == SEL_W'(c));
    end
  end

  for (genvar c = 0; c < int'(DEMUX_SIZE); c++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[c]),
      .wr_data  (in_data),
      .rd_ready (out_ready[c]),
      .valid    (out_valid[c]),
      .data     (out_data[c*DATA_W +: DATA_W])
    );
  end

  // Clear is applied first, then a same-cycle drop counts on top of it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end
    if (drop && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_demux_generic_buf.sv
module tb_demux_generic_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT a: N=8, DATA_W=8 ----------------
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [2:0]  a_in_sel = '0;
  logic [7:0]  a_in_data = '0;
  logic [7:0]  a_out_valid;
  logic [7:0]  a_out_ready = '1;
  logic [63:0] a_out_data;
  logic [7:0]  a_err_cnt;
  logic        a_err_clr = 1'b0;

  demux_generic_buf #(.DEMUX_SIZE(8), .DATA_W(8), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .err_cnt(a_err_cnt),
    .err_clr(a_err_clr)
  );

  // ---------------- DUT b: N=6, DATA_W=8 ----------------
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [2:0]  b_in_sel = '0;
  logic [7:0]  b_in_data = '0;
  logic [5:0]  b_out_valid;
  logic [5:0]  b_out_ready = '1;
  logic [47:0] b_out_data;
  logic [7:0]  b_err_cnt;
  logic        b_err_clr = 1'b0;

  demux_generic_buf #(.DEMUX_SIZE(6), .DATA_W(8), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .err_cnt(b_err_cnt),
    .err_clr(b_err_clr)
  );

  // ---------------- DUT s: N=5, ERR_W=2 (saturation) ----------------
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [2:0]  s_in_sel = '0;
  logic [0:0]  s_in_data = '0;
  logic [4:0]  s_out_valid;
  logic [4:0]  s_out_ready = '1;
  logic [4:0]  s_out_data;
  logic [1:0]  s_err_cnt;
  logic        s_err_clr = 1'b0;

  demux_generic_buf #(.DEMUX_SIZE(5), .DATA_W(1), .ERR_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_sel(s_in_sel), .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .err_cnt(s_err_cnt),
    .err_clr(s_err_clr)
  );

  // ---------------- DUT o: N=1, DATA_W=1 ----------------
  logic        o_in_valid = 1'b0;
  logic        o_in_ready;
  logic [0:0]  o_in_sel = '0;
  logic [0:0]  o_in_data = '0;
  logic [0:0]  o_out_valid;
  logic [0:0]  o_out_ready = '0;
  logic [0:0]  o_out_data;
  logic [7:0]  o_err_cnt;
  logic        o_err_clr = 1'b0;

  demux_generic_buf #(.DEMUX_SIZE(1), .DATA_W(1), .ERR_W(8)) u_o (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_sel(o_in_sel), .in_data(o_in_data), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_data(o_out_data), .err_cnt(o_err_cnt),
    .err_clr(o_err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [7:0]  data;
    logic [7:0]  rdy;
    logic        exp_rdy;
    logic [7:0]  exp_vld;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Routing: all ready, one word per channel, previous channel drains each cycle.
    tbl[0]  = '{1'b1, 3'd0, 8'hA0, 8'hFF, 1'b1, 8'h01, 64'h0000_0000_0000_00A0};
    tbl[1]  = '{1'b1, 3'd1, 8'hA1, 8'hFF, 1'b1, 8'h02, 64'h0000_0000_0000_A1A0};
    tbl[2]  = '{1'b1, 3'd2, 8'hA2, 8'hFF, 1'b1, 8'h04, 64'h0000_0000_00A2_A1A0};
    tbl[3]  = '{1'b1, 3'd3, 8'hA3, 8'hFF, 1'b1, 8'h08, 64'h0000_0000_A3A2_A1A0};
    tbl[4]  = '{1'b1, 3'd4, 8'hA4, 8'hFF, 1'b1, 8'h10, 64'h0000_00A4_A3A2_A1A0};
    tbl[5]  = '{1'b1, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h20, 64'h0000_A5A4_A3A2_A1A0};
    tbl[6]  = '{1'b1, 3'd6, 8'hA6, 8'hFF, 1'b1, 8'h40, 64'h00A6_A5A4_A3A2_A1A0};
    tbl[7]  = '{1'b1, 3'd7, 8'hA7, 8'hFF, 1'b1, 8'h80, 64'hA7A6_A5A4_A3A2_A1A0};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 64'hA7A6_A5A4_A3A2_A1A0};
    // Backpressure on channel 3.
    tbl[9]  = '{1'b1, 3'd3, 8'h33, 8'hF7, 1'b1, 8'h08, 64'hA7A6_A5A4_33A2_A1A0};
    tbl[10] = '{1'b1, 3'd3, 8'h44, 8'hF7, 1'b0, 8'h08, 64'hA7A6_A5A4_33A2_A1A0};
    tbl[11] = '{1'b0, 3'd3, 8'h44, 8'hF7, 1'b0, 8'h08, 64'hA7A6_A5A4_33A2_A1A0};
    tbl[12] = '{1'b1, 3'd5, 8'h55, 8'hF7, 1'b1, 8'h28, 64'hA7A6_55A4_33A2_A1A0};
    tbl[13] = '{1'b1, 3'd3, 8'h44, 8'hF7, 1'b0, 8'h08, 64'hA7A6_55A4_33A2_A1A0};
    tbl[14] = '{1'b1, 3'd3, 8'h44, 8'hFF, 1'b1, 8'h08, 64'hA7A6_55A4_44A2_A1A0};
    tbl[15] = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 64'hA7A6_55A4_44A2_A1A0};

    // ---- Reset state ----
    #2;
    check("rst_a_out_valid", 64'(a_out_valid), 64'h0);
    check("rst_a_out_data", a_out_data, 64'h0);
    check("rst_a_err_cnt", 64'(a_err_cnt), 64'h0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Routing and backpressure table on N=8 ----
    for (int i = 0; i < 16; i++) begin
      a_in_valid  = tbl[i].vld;
      a_in_sel    = tbl[i].sel;
      a_in_data   = tbl[i].data;
      a_out_ready = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(a_in_ready), 64'(tbl[i].exp_rdy));
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(a_out_valid), 64'(tbl[i].exp_vld));
      check($sformatf("vec%0d_out_data", i), a_out_data, tbl[i].exp_data);
    end
    a_in_valid = 1'b0;

    // ---- Out-of-range on N=6 ----
    b_in_valid = 1'b1;
    b_in_sel   = 3'd6;
    b_in_data  = 8'h66;
    #1;
    check("oor6_in_ready", 64'(b_in_ready), 64'h1);
    tick();
    check("oor6_err_cnt", 64'(b_err_cnt), 64'd1);
    b_in_sel = 3'd7;
    #1;
    check("oor7_in_ready", 64'(b_in_ready), 64'h1);
    tick();
    check("oor7_err_cnt", 64'(b_err_cnt), 64'd2);
    check("oor_out_valid", 64'(b_out_valid), 64'h0);
    b_err_clr = 1'b1;
    tick();
    check("clr_with_drop_err_cnt", 64'(b_err_cnt), 64'd1);
    b_in_valid = 1'b0;
    tick();
    check("clr_alone_err_cnt", 64'(b_err_cnt), 64'd0);
    b_err_clr  = 1'b0;
    b_in_valid = 1'b1;
    tick();
    check("redrop_err_cnt", 64'(b_err_cnt), 64'd1);
    // A valid word lands on channel 2 and is held for the reset check.
    b_out_ready = '0;
    b_in_sel    = 3'd2;
    b_in_data   = 8'h5A;
    tick();
    b_in_valid = 1'b0;
    check("b_ch2_valid", 64'(b_out_valid), 64'h04);
    check("b_ch2_data", 64'(b_out_data), 64'h0000_005A_0000);

    // ---- Saturation, ERR_W=2 ----
    s_in_valid = 1'b1;
    s_in_sel   = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat%0d_err_cnt", i), 64'(s_err_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    s_in_valid = 1'b0;
    check("sat_out_valid", 64'(s_out_valid), 64'h0);

    // ---- N=1 ----
    o_in_valid = 1'b1;
    o_in_sel   = 1'b0;
    o_in_data  = 1'b1;
    #1;
    check("n1_in_ready_empty", 64'(o_in_ready), 64'h1);
    tick();
    check("n1_out_valid", 64'(o_out_valid), 64'h1);
    check("n1_out_data", 64'(o_out_data), 64'h1);
    check("n1_in_ready_full", 64'(o_in_ready), 64'h0);
    o_in_sel  = 1'b1;
    o_in_data = 1'b0;
    #1;
    check("n1_drop_in_ready", 64'(o_in_ready), 64'h1);
    tick();
    o_in_valid = 1'b0;
    check("n1_err_cnt", 64'(o_err_cnt), 64'd1);
    check("n1_hold_data", 64'(o_out_data), 64'h1);

    // ---- Reset mid-traffic: asynchronous, checked before any edge ----
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd2;
    a_in_data   = 8'hC3;
    a_out_ready = '0;
    tick();
    a_in_valid = 1'b0;
    check("pre_rst_a_valid", 64'(a_out_valid), 64'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a_valid", 64'(a_out_valid), 64'h0);
    check("async_rst_b_valid", 64'(b_out_valid), 64'h0);
    check("async_rst_b_err", 64'(b_err_cnt), 64'h0);
    check("async_rst_s_err", 64'(s_err_cnt), 64'h0);
    check("async_rst_o_valid", 64'(o_out_valid), 64'h0);
    check("async_rst_o_err", 64'(o_err_cnt), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_a_data", a_out_data, 64'h0);
    check("post_rst_b_data", 64'(b_out_data), 64'h0);
    check("post_rst_o_data", 64'(o_out_data), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
